// File: rtl/pc_gen_multi_stage_pkg.sv
// Shared types for the pre-fetch PC generator: address type, next-PC source codes,
// redirect source priority and the per-slot fetch bus element.
package pc_gen_multi_stage_pkg;

  typedef logic [31:0] virt_t;

  typedef logic [1:0] next_pc_src_t;
  localparam next_pc_src_t ST_SEQ    = 2'd0;
  localparam next_pc_src_t ST_DELAY  = 2'd1;
  localparam next_pc_src_t ST_TARGET = 2'd2;

  typedef enum logic [1:0] {
    RS_NONE  = 2'd0,
    RS_FLUSH = 2'd1,
    RS_CORR  = 2'd2,
    RS_BP    = 2'd3
  } redirect_src_t;

  typedef struct packed {
    logic  valid;
    virt_t pc;
  } fetch_slot_t;

  // Slot index width; a single-slot block still carries a 1-bit index.
  function automatic int slot_w(input int fw);
    return (fw > 1) ? $clog2(fw) : 1;
  endfunction

endpackage

// File: rtl/pc_gen_multi_stage_redirect_arbiter.sv
// Priority select of redirect sources (flush > correction > taken prediction);
// returns the redirect PC and the state the generator moves to.
module pc_redirect_arbiter
  import pc_gen_multi_stage_pkg::*;
#(
  parameter int FETCH_WIDTH = 2,
  parameter bit DELAY_SLOT  = 1'b1
) (
  input  logic                               flush_i,
  input  virt_t                              flush_target_i,
  input  logic                               corr_valid_i,
  input  virt_t                              corr_target_i,
  input  logic                               bp_valid_i,
  input  logic                               bp_taken_i,
  input  logic [slot_w(FETCH_WIDTH)-1:0]     bp_slot_i,
  input  virt_t                              bp_target_i,
  input  next_pc_src_t                       state_i,
  output logic                               redir_valid_o,
  output virt_t                              redir_pc_o,
  output next_pc_src_t                       redir_state_o
);

  localparam int SLOT_W = slot_w(FETCH_WIDTH);

  redirect_src_t src;

  // Predictions only count while fetching sequentially.
  always_comb begin
    src = RS_NONE;
    if (flush_i)                                              src = RS_FLUSH;
    else if (corr_valid_i)                                    src = RS_CORR;
    else if (bp_valid_i && bp_taken_i && state_i == ST_SEQ)   src = RS_BP;
  end

  always_comb begin
    redir_valid_o = (src != RS_NONE);
    redir_pc_o    = '0;
    redir_state_o = ST_TARGET;
    case (src)
      RS_FLUSH: redir_pc_o = flush_target_i;
      RS_CORR:  redir_pc_o = corr_target_i;
      RS_BP: begin
        redir_pc_o = bp_target_i;
        // A branch in the last slot still owes its delay slot from the next block.
        if (DELAY_SLOT && bp_slot_i == SLOT_W'(FETCH_WIDTH - 1))
          redir_state_o = ST_DELAY;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pc_gen_multi_stage.sv
// Pre-fetch PC generator: one block-aligned I-cache request per cycle, per-slot PCs and
// valid mask for the fetch stage, redirects held until the I-cache accepts them.
module pc_gen_multi_stage
  import pc_gen_multi_stage_pkg::*;
#(
  parameter int          FETCH_WIDTH = 2,
  parameter logic [31:0] RESET_PC    = 32'hbfc0_0000,
  parameter bit          DELAY_SLOT  = 1'b1
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  flush,
  input  logic [31:0]                           flush_target,
  input  logic                                  fs_allowin,
  input  logic                                  bp_valid,
  input  logic                                  bp_taken,
  input  logic [slot_w(FETCH_WIDTH)-1:0]        bp_slot,
  input  logic [31:0]                           bp_target,
  input  logic                                  corr_valid,
  input  logic [31:0]                           corr_target,
  output logic                                  icache_req,
  output logic [31:0]                           icache_addr,
  input  logic                                  icache_addr_ok,
  output logic [31:0]                           inst_vaddr,
  output logic                                  pfs_to_valid,
  output logic [FETCH_WIDTH-1:0][31:0]          out_pc,
  output logic [FETCH_WIDTH-1:0]                out_mask
);

  localparam int    BLOCK_BYTES = 4 * FETCH_WIDTH;
  localparam virt_t BLOCK_MASK  = ~virt_t'(BLOCK_BYTES - 1);

  typedef fetch_slot_t [FETCH_WIDTH-1:0] pfs_bus_t;

  logic         pfs_valid_q, pfs_valid_d;
  next_pc_src_t state_q, state_d;
  virt_t        cur_pc_q, cur_pc_d;
  virt_t        redirect_pc_q, redirect_pc_d;

  virt_t        next_pc;
  virt_t        off_slot;
  logic         redir_valid;
  virt_t        redir_pc;
  next_pc_src_t redir_state;
  pfs_bus_t     pfs_bus;

  assign next_pc      = (state_q == ST_TARGET) ? redirect_pc_q : cur_pc_q;
  assign icache_addr  = next_pc & BLOCK_MASK;
  assign inst_vaddr   = icache_addr;
  assign icache_req   = pfs_valid_q & fs_allowin & ~flush;
  assign pfs_to_valid = icache_req & icache_addr_ok;
  assign off_slot     = (next_pc & ~BLOCK_MASK) >> 2;

  pc_redirect_arbiter #(
    .FETCH_WIDTH (FETCH_WIDTH),
    .DELAY_SLOT  (DELAY_SLOT)
  ) u_arb (
    .flush_i        (flush),
    .flush_target_i (flush_target),
    .corr_valid_i   (corr_valid),
    .corr_target_i  (corr_target),
    .bp_valid_i     (bp_valid),
    .bp_taken_i     (bp_taken),
    .bp_slot_i      (bp_slot),
    .bp_target_i    (bp_target),
    .state_i        (state_q),
    .redir_valid_o  (redir_valid),
    .redir_pc_o     (redir_pc),
    .redir_state_o  (redir_state)
  );

  // Slots before the entry offset, and all but slot 0 of a delay-slot block, are masked.
  for (genvar g = 0; g < FETCH_WIDTH; g++) begin : g_slot
    assign pfs_bus[g].pc    = icache_addr + virt_t'(4 * g);
    assign pfs_bus[g].valid = pfs_to_valid && (virt_t'(g) >= off_slot) &&
                              !(state_q == ST_DELAY && g != 0);
    assign out_pc[g]        = pfs_bus[g].pc;
    assign out_mask[g]      = pfs_bus[g].valid;
  end

  always_comb begin
    pfs_valid_d   = 1'b1;
    state_d       = state_q;
    cur_pc_d      = cur_pc_q;
    redirect_pc_d = redirect_pc_q;
    if (pfs_to_valid)
      cur_pc_d = icache_addr + virt_t'(BLOCK_BYTES);
    if (redir_valid) begin
      state_d       = redir_state;
      redirect_pc_d = redir_pc;
    end else if (pfs_to_valid) begin
      case (state_q)
        ST_DELAY:  state_d = ST_TARGET;
        ST_TARGET: state_d = ST_SEQ;
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pfs_valid_q   <= 1'b0;
      state_q       <= ST_SEQ;
      cur_pc_q      <= RESET_PC;
      redirect_pc_q <= '0;
    end else begin
      pfs_valid_q   <= pfs_valid_d;
      state_q       <= state_d;
      cur_pc_q      <= cur_pc_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  // A taken prediction arriving while a redirect is outstanding is dropped; flag it.
  bp_outside_seq: assert property (@(posedge clk) disable iff (reset)
    (bp_valid && bp_taken && !flush && !corr_valid) |-> (state_q == ST_SEQ));

endmodule

// File: tb/tb_pc_gen_multi_stage.sv
// Bench for pc_gen_multi_stage: three configurations driven from one stimulus stream,
// checked every cycle against a behavioural model plus hand-computed fetch logs.
module tb_pc_gen_multi_stage;

  localparam int FWS [3] = '{2, 2, 4};
  localparam int DSS [3] = '{1, 0, 1};
  localparam logic [31:0] RST_PC = 32'hbfc0_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic [31:0] flush_target = '0;
  logic        fs_allowin = 1'b0;
  logic        bp_valid = 1'b0;
  logic        bp_taken = 1'b0;
  logic [1:0]  bp_slot = '0;
  logic [31:0] bp_target = '0;
  logic        corr_valid = 1'b0;
  logic [31:0] corr_target = '0;
  logic        icache_addr_ok = 1'b0;

  logic             req0, req1, req2, ptv0, ptv1, ptv2;
  logic [31:0]      addr0, addr1, addr2, va0, va1, va2;
  logic [1:0][31:0] pc0, pc1;
  logic [3:0][31:0] pc2;
  logic [1:0]       m0, m1;
  logic [3:0]       m2;

  always #5 clk = ~clk;

  pc_gen_multi_stage #(.FETCH_WIDTH(2), .RESET_PC(RST_PC), .DELAY_SLOT(1'b1)) u_fw2_ds (
    .clk(clk), .reset(reset), .flush(flush), .flush_target(flush_target),
    .fs_allowin(fs_allowin), .bp_valid(bp_valid), .bp_taken(bp_taken),
    .bp_slot(bp_slot[0:0]), .bp_target(bp_target), .corr_valid(corr_valid),
    .corr_target(corr_target), .icache_req(req0), .icache_addr(addr0),
    .icache_addr_ok(icache_addr_ok), .inst_vaddr(va0), .pfs_to_valid(ptv0),
    .out_pc(pc0), .out_mask(m0));

  pc_gen_multi_stage #(.FETCH_WIDTH(2), .RESET_PC(RST_PC), .DELAY_SLOT(1'b0)) u_fw2_nd (
    .clk(clk), .reset(reset), .flush(flush), .flush_target(flush_target),
    .fs_allowin(fs_allowin), .bp_valid(bp_valid), .bp_taken(bp_taken),
    .bp_slot(bp_slot[0:0]), .bp_target(bp_target), .corr_valid(corr_valid),
    .corr_target(corr_target), .icache_req(req1), .icache_addr(addr1),
    .icache_addr_ok(icache_addr_ok), .inst_vaddr(va1), .pfs_to_valid(ptv1),
    .out_pc(pc1), .out_mask(m1));

  pc_gen_multi_stage #(.FETCH_WIDTH(4), .RESET_PC(RST_PC), .DELAY_SLOT(1'b1)) u_fw4_ds (
    .clk(clk), .reset(reset), .flush(flush), .flush_target(flush_target),
    .fs_allowin(fs_allowin), .bp_valid(bp_valid), .bp_taken(bp_taken),
    .bp_slot(bp_slot), .bp_target(bp_target), .corr_valid(corr_valid),
    .corr_target(corr_target), .icache_req(req2), .icache_addr(addr2),
    .icache_addr_ok(icache_addr_ok), .inst_vaddr(va2), .pfs_to_valid(ptv2),
    .out_pc(pc2), .out_mask(m2));

  logic        act_req [3];
  logic        act_ptv [3];
  logic [31:0] act_addr [3];
  logic [31:0] act_va [3];
  logic [7:0]  act_mask [3];
  logic [31:0] act_pc [3][8];

  always_comb begin
    act_req  = '{req0, req1, req2};
    act_ptv  = '{ptv0, ptv1, ptv2};
    act_addr = '{addr0, addr1, addr2};
    act_va   = '{va0, va1, va2};
    act_mask = '{{6'b0, m0}, {6'b0, m1}, {4'b0, m2}};
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 8; i++) act_pc[k][i] = '0;
    for (int i = 0; i < 2; i++) begin
      act_pc[0][i] = pc0[i];
      act_pc[1][i] = pc1[i];
    end
    for (int i = 0; i < 4; i++) act_pc[2][i] = pc2[i];
  end

  int tests_run = 0;
  int tests_failed = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Model: a fetch target is either the sequential PC, or a pending redirect target that may
  // first owe one delay-slot block (fetched sequentially, slot 0 only).
  logic        started = 1'b0;
  logic        m_valid [3];
  logic        m_pend [3];
  logic        m_dslot [3];
  logic [31:0] m_pc [3];
  logic [31:0] m_tgt [3];

  function automatic void model_out(input int k, output logic er, output logic ep,
                                    output logic [31:0] ea, output logic [7:0] em);
    logic [31:0] fetch, bb;
    int off;
    bb    = 32'(4 * FWS[k]);
    fetch = (m_pend[k] && !m_dslot[k]) ? m_tgt[k] : m_pc[k];
    ea    = fetch - (fetch % bb);
    off   = int'((fetch % bb) / 4);
    er    = m_valid[k] && fs_allowin && !flush;
    ep    = er && icache_addr_ok;
    em    = '0;
    for (int i = 0; i < FWS[k]; i++)
      em[i] = ep && (i >= off) && !(m_dslot[k] && i != 0);
  endfunction

  logic        u_er, u_ep;
  logic [31:0] u_ea;
  logic [7:0]  u_em;

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      model_out(k, u_er, u_ep, u_ea, u_em);
      if (reset) begin
        m_valid[k] = 1'b0; m_pend[k] = 1'b0; m_dslot[k] = 1'b0;
        m_pc[k] = RST_PC;  m_tgt[k] = '0;
      end else begin
        m_valid[k] = 1'b1;
        if (u_ep) m_pc[k] = u_ea + 32'(4 * FWS[k]);
        if (flush) begin
          m_pend[k] = 1'b1; m_dslot[k] = 1'b0; m_tgt[k] = flush_target;
        end else if (corr_valid) begin
          m_pend[k] = 1'b1; m_dslot[k] = 1'b0; m_tgt[k] = corr_target;
        end else if (bp_valid && bp_taken && !m_pend[k]) begin
          m_pend[k]  = 1'b1;
          m_tgt[k]   = bp_target;
          m_dslot[k] = (DSS[k] != 0) && ((int'(bp_slot) % FWS[k]) == FWS[k] - 1);
        end else if (u_ep) begin
          if (m_dslot[k]) m_dslot[k] = 1'b0;
          else            m_pend[k]  = 1'b0;
        end
      end
    end
    if (reset) started = 1'b1;
  end

  logic [39:0] log0 [$];
  logic [39:0] log1 [$];
  logic [39:0] log2 [$];
  logic [39:0] exp_q [$];

  logic        c_er, c_ep;
  logic [31:0] c_ea;
  logic [7:0]  c_em;

  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 3; k++) begin
        model_out(k, c_er, c_ep, c_ea, c_em);
        chk($sformatf("u%0d icache_req", k), 64'(act_req[k]), 64'(c_er));
        chk($sformatf("u%0d pfs_to_valid", k), 64'(act_ptv[k]), 64'(c_ep));
        chk($sformatf("u%0d out_mask", k), 64'(act_mask[k]), 64'(c_em));
        if (m_valid[k]) begin
          chk($sformatf("u%0d icache_addr", k), 64'(act_addr[k]), 64'(c_ea));
          chk($sformatf("u%0d inst_vaddr", k), 64'(act_va[k]), 64'(c_ea));
          for (int i = 0; i < FWS[k]; i++)
            chk($sformatf("u%0d out_pc[%0d]", k, i), 64'(act_pc[k][i]),
                64'(c_ea + 32'(4 * i)));
        end
        if (act_ptv[k]) begin
          case (k)
            0:       log0.push_back({act_mask[k], act_addr[k]});
            1:       log1.push_back({act_mask[k], act_addr[k]});
            default: log2.push_back({act_mask[k], act_addr[k]});
          endcase
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    reset = 1'b0; flush = 1'b0; corr_valid = 1'b0;
    bp_valid = 1'b0; bp_taken = 1'b0; bp_slot = '0;
    fs_allowin = 1'b1; icache_addr_ok = 1'b1;
  endtask

  task automatic ex(input logic [31:0] a, input logic [7:0] m);
    exp_q.push_back({m, a});
  endtask

  task automatic chk_log(input int k, input string nm);
    logic [39:0] got [$];
    case (k)
      0:       got = log0;
      1:       got = log1;
      default: got = log2;
    endcase
    chk({nm, " count"}, 64'(got.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk($sformatf("%s[%0d]", nm, i), 64'(got[i]), 64'(exp_q[i]));
    exp_q.delete();
  endtask

  // Reset while requests are live, then one idle cycle in which nothing may be requested.
  task automatic start_scn(input string nm);
    quiet(); reset = 1'b1;
    tick();
    quiet();
    log0.delete(); log1.delete(); log2.delete();
    #1;
    chk({nm, " post-reset req"}, 64'(req0), 64'(0));
    chk({nm, " post-reset pfs_to_valid"}, 64'(ptv0), 64'(0));
    chk({nm, " post-reset mask"}, 64'(m0), 64'(0));
    tick();
  endtask

  initial begin
    quiet(); reset = 1'b1; fs_allowin = 1'b1; icache_addr_ok = 1'b1;
    repeat (2) tick();

    // Sequential fetch from the reset vector
    start_scn("seq");
    repeat (3) tick();
    ex(32'hbfc00000, 8'h3); ex(32'hbfc00008, 8'h3); ex(32'hbfc00010, 8'h3);
    chk_log(0, "seq fw2");
    ex(32'hbfc00000, 8'hf); ex(32'hbfc00010, 8'hf); ex(32'hbfc00020, 8'hf);
    chk_log(2, "seq fw4");

    // Taken branch in the last slot of 0xbfc00008
    start_scn("bp1");
    tick();
    bp_valid = 1'b1; bp_taken = 1'b1; bp_slot = 2'd1; bp_target = 32'hbfc00104;
    tick();
    quiet();
    repeat (3) tick();
    ex(32'hbfc00000, 8'h3); ex(32'hbfc00008, 8'h3); ex(32'hbfc00010, 8'h1);
    ex(32'hbfc00100, 8'h2); ex(32'hbfc00108, 8'h3);
    chk_log(0, "bp1 fw2 ds");
    ex(32'hbfc00000, 8'h3); ex(32'hbfc00008, 8'h3); ex(32'hbfc00100, 8'h2);
    ex(32'hbfc00108, 8'h3); ex(32'hbfc00110, 8'h3);
    chk_log(1, "bp1 fw2 nods");
    ex(32'hbfc00000, 8'hf); ex(32'hbfc00010, 8'hf); ex(32'hbfc00100, 8'he);
    ex(32'hbfc00110, 8'hf); ex(32'hbfc00120, 8'hf);
    chk_log(2, "bp1 fw4");

    // Taken branch in slot 0: no delay block owed
    start_scn("bp0");
    tick();
    bp_valid = 1'b1; bp_taken = 1'b1; bp_slot = 2'd0; bp_target = 32'hbfc00104;
    tick();
    quiet();
    repeat (2) tick();
    ex(32'hbfc00000, 8'h3); ex(32'hbfc00008, 8'h3); ex(32'hbfc00100, 8'h2);
    ex(32'hbfc00108, 8'h3);
    chk_log(0, "bp0 fw2 ds");

    // Correction held across addr_ok=0 and fs_allowin=0
    start_scn("hold");
    tick();
    corr_valid = 1'b1; corr_target = 32'hbfc00204;
    tick();
    quiet(); icache_addr_ok = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("hold addr c%0d", c), 64'(addr0), 64'(32'hbfc00200));
      chk($sformatf("hold ptv c%0d", c), 64'(ptv0), 64'(0));
      tick();
    end
    fs_allowin = 1'b0; icache_addr_ok = 1'b1;
    #1;
    chk("hold allowin req", 64'(req0), 64'(0));
    tick();
    quiet();
    repeat (2) tick();
    ex(32'hbfc00000, 8'h3); ex(32'hbfc00008, 8'h3); ex(32'hbfc00200, 8'h2);
    ex(32'hbfc00208, 8'h3);
    chk_log(0, "hold fw2");

    // Flush with concurrent correction and addr_ok
    start_scn("flush");
    tick();
    flush = 1'b1; flush_target = 32'hbfc00380;
    corr_valid = 1'b1; corr_target = 32'hbfc00500;
    #1;
    chk("flush req", 64'(req0), 64'(0));
    tick();
    quiet();
    repeat (2) tick();
    ex(32'hbfc00000, 8'h3); ex(32'hbfc00380, 8'h3); ex(32'hbfc00388, 8'h3);
    chk_log(0, "flush fw2");

    // Unaligned correction and address wrap
    start_scn("wrap");
    corr_valid = 1'b1; corr_target = 32'h0000_0014;
    tick();
    quiet();
    repeat (2) tick();
    corr_valid = 1'b1; corr_target = 32'hffff_fff0;
    tick();
    quiet();
    repeat (3) tick();
    ex(32'hbfc00000, 8'h3); ex(32'h00000010, 8'h2); ex(32'h00000018, 8'h3);
    ex(32'h00000020, 8'h3); ex(32'hfffffff0, 8'h3); ex(32'hfffffff8, 8'h3);
    ex(32'h00000000, 8'h3);
    chk_log(0, "wrap fw2");
    ex(32'hbfc00000, 8'hf); ex(32'h00000010, 8'he); ex(32'h00000020, 8'hf);
    ex(32'h00000030, 8'hf); ex(32'hfffffff0, 8'hf); ex(32'h00000000, 8'hf);
    ex(32'h00000010, 8'hf);
    chk_log(2, "wrap fw4");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
